// File: rtl/adsr_pkg.sv
// adsr_pkg: constants and types shared by the envelope detector and the
// ADSR generator.
//   WAVE_MAX     full-scale wave/envelope value
//   det_state_e  detector state encoding (driven on DetState)
//   rate_step    one smoothing step: ((diff * coef) >> 24) + 1
package adsr_pkg;

  localparam logic [23:0] WAVE_MAX = 24'hFFFFFF;

  typedef enum logic [1:0] {
    DET_IDLE    = 2'b00,
    DET_ATTACK  = 2'b01,
    DET_HOLD    = 2'b10,
    DET_RELEASE = 2'b11
  } det_state_e;

  // The product is formed at 48 bits, so it cannot overflow. The shifted
  // product is below 2^24, so the +1 still fits in 25 bits.
  function automatic logic [24:0] rate_step(input logic [23:0] diff,
                                            input logic [23:0] coef);
    logic [47:0] prod;
    prod = {24'd0, diff} * {24'd0, coef};
    return 25'((prod >> 24) + 48'd1);
  endfunction

endpackage

// File: rtl/envelope_detector_if.sv
// envelope_detector_if: sample/coefficient inputs and detector outputs.
//   master: drives SampleValid, Sample, Attack, Release, ThreshOn, ThreshOff;
//           observes Envelope, EnvValid, Gate, Running, DetState
//   slave : the detector side (opposite directions)
interface envelope_detector_if;
  logic        SampleValid;
  logic [23:0] Sample;
  logic [23:0] Attack;
  logic [23:0] Release;
  logic [23:0] ThreshOn;
  logic [23:0] ThreshOff;
  logic [23:0] Envelope;
  logic        EnvValid;
  logic        Gate;
  logic        Running;
  logic [1:0]  DetState;

  modport master (
    output SampleValid, Sample, Attack, Release, ThreshOn, ThreshOff,
    input  Envelope, EnvValid, Gate, Running, DetState
  );

  modport slave (
    input  SampleValid, Sample, Attack, Release, ThreshOn, ThreshOff,
    output Envelope, EnvValid, Gate, Running, DetState
  );
endinterface

// File: rtl/env_magnitude.sv
// env_magnitude: stage 1 of the envelope detector. It registers the
// saturated magnitude of an offset-binary sample.
//   Clock, Reset : clock and synchronous active-low reset
//   in_valid     : a sample is present this cycle
//   sample       : offset-binary sample (24'h800000 is zero)
//   m_valid      : mag holds a new value this cycle
//   mag          : min(|sample - 24'h800000| << 1, WAVE_MAX)
module env_magnitude #(
  parameter logic [23:0] WAVE_MAX = adsr_pkg::WAVE_MAX
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        in_valid,
  input  logic [23:0] sample,
  output logic        m_valid,
  output logic [23:0] mag
);

  logic [23:0] abs_v;
  logic [24:0] dbl;
  logic [23:0] sat;

  always_comb begin
    abs_v = (sample >= 24'h800000) ? sample - 24'h800000 : 24'h800000 - sample;
    dbl   = {abs_v, 1'b0};
    sat   = (dbl > {1'b0, WAVE_MAX}) ? WAVE_MAX : dbl[23:0];
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      m_valid <= 1'b0;
      mag     <= '0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) mag <= sat;
    end
  end

endmodule

// File: rtl/envelope_detector.sv
// envelope_detector: attack/release envelope follower with a gate-recovery
// FSM. The pipeline has two stages: the magnitude, then the envelope update.
// The FSM runs in the cycle after each EnvValid pulse.
//   Clock, Reset : clock and synchronous active-low reset
//   bus (slave)  : SampleValid/Sample in, Attack/Release rates,
//                  ThreshOn/ThreshOff levels; Envelope, EnvValid, Gate,
//                  Running, DetState out
module envelope_detector #(
  parameter logic [23:0] WAVE_MAX     = adsr_pkg::WAVE_MAX,
  parameter logic [15:0] HOLD_SAMPLES = 16'd16,
  parameter logic [23:0] ENV_FLOOR    = 24'h000100
) (
  input  logic                Clock,
  input  logic                Reset,
  envelope_detector_if.slave  bus
);

  logic        m_vld;
  logic [23:0] mag;

  env_magnitude #(.WAVE_MAX(WAVE_MAX)) u_mag (
    .Clock    (Clock),
    .Reset    (Reset),
    .in_valid (bus.SampleValid),
    .sample   (bus.Sample),
    .m_valid  (m_vld),
    .mag      (mag)
  );

  // ---- stage 2: envelope update ----
  logic [23:0] env_q;
  logic        env_vld_q;
  logic        rose_q;
  logic        up;
  logic [23:0] diff, coef, env_nxt;
  logic [24:0] step;

  always_comb begin
    up   = mag > env_q;
    diff = up ? mag - env_q : env_q - mag;
    coef = up ? WAVE_MAX - bus.Attack : WAVE_MAX - bus.Release;
    step = adsr_pkg::rate_step(diff, coef);
    // If the step would overshoot, clamp to M. This path also covers
    // M == Envelope: diff is 0, so the step always overshoots.
    if (step >= {1'b0, diff}) env_nxt = mag;
    else if (up)              env_nxt = env_q + step[23:0];
    else                      env_nxt = env_q - step[23:0];
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      env_q     <= '0;
      env_vld_q <= 1'b0;
      rose_q    <= 1'b0;
    end else begin
      env_vld_q <= m_vld;
      if (m_vld) begin
        env_q  <= env_nxt;
        rose_q <= up;
      end
    end
  end

  // ---- gate FSM ----
  adsr_pkg::det_state_e st_q;
  logic        gate_q, run_q;
  logic [15:0] hold_cnt;
  logic [23:0] off_lvl;

  assign off_lvl = (bus.ThreshOff < bus.ThreshOn) ? bus.ThreshOff : bus.ThreshOn;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      st_q     <= adsr_pkg::DET_IDLE;
      gate_q   <= 1'b0;
      run_q    <= 1'b0;
      hold_cnt <= '0;
    end else if (env_vld_q) begin
      case (st_q)
        adsr_pkg::DET_IDLE:
          if (env_q >= bus.ThreshOn) begin
            st_q     <= adsr_pkg::DET_ATTACK;
            gate_q   <= 1'b1;
            run_q    <= 1'b1;
            hold_cnt <= '0;
          end
        adsr_pkg::DET_ATTACK:
          if (!rose_q) begin
            st_q     <= adsr_pkg::DET_HOLD;
            hold_cnt <= '0;
          end
        adsr_pkg::DET_HOLD:
          // The counter value from earlier updates is compared first, so
          // the gate stays high for HOLD_SAMPLES updates after HOLD entry.
          if (hold_cnt == HOLD_SAMPLES && env_q < off_lvl) begin
            st_q   <= adsr_pkg::DET_RELEASE;
            gate_q <= 1'b0;
          end else if (hold_cnt != HOLD_SAMPLES) begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        adsr_pkg::DET_RELEASE:
          if (env_q >= bus.ThreshOn) begin
            st_q     <= adsr_pkg::DET_ATTACK;
            gate_q   <= 1'b1;
            hold_cnt <= '0;
          end else if (env_q < ENV_FLOOR) begin
            st_q  <= adsr_pkg::DET_IDLE;
            run_q <= 1'b0;
          end
        default: st_q <= adsr_pkg::DET_IDLE;
      endcase
    end
  end

  assign bus.Envelope = env_q;
  assign bus.EnvValid = env_vld_q;
  assign bus.Gate     = gate_q;
  assign bus.Running  = run_q;
  assign bus.DetState = st_q;

endmodule
